shift_deserializer: RTL and testbench
=====================================

Name: shift_deserializer

Overview:
- Sequential counterpart of the team's combinational shifter: serial-in, parallel-out word collector.
- Accepts one bit per qualified clock and shifts it in, MSB-first (shift left) or LSB-first (shift right).
- Presents each completed DATA_WIDTH-bit word on a registered output with a valid/ready handshake.
- Used wherever the Z80 board receives bit-serial data (serial links, SPI-style peripherals) and hands bytes to the bus side.

Parameters:
- DATA_WIDTH, 8, word width in bits (>= 2).
- CNT_WIDTH, 4, bit-counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_bit  input  1  serial data bit.
- i_bit_valid  input  1  i_bit is sampled on this edge.
- i_msb_first  input  1  1 = first received bit becomes o_data[DATA_WIDTH-1]; 0 = first bit becomes o_data[0].
- i_clear  input  1  synchronous abort of the partial word; clears the output and overrun state.
- o_data  output  DATA_WIDTH  last completed word.
- o_valid  output  1  o_data holds an unconsumed word.
- i_ready  input  1  consumer accepts o_data when o_valid && i_ready.
- o_busy  output  1  partial word in progress (state SHIFT).
- o_overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (i_reset=1 at edge): state IDLE, bit count 0, shift register 0, o_data 0, o_valid 0, o_busy 0, o_overrun 0.
- Priority: i_reset > i_clear > all other activity.
- i_clear has the same effect as reset on every register. A bit presented in the same cycle is discarded. An o_valid && i_ready in the same cycle is not counted as a transfer.
- Shift-side FSM:
  - IDLE (count 0): on i_bit_valid, latch i_msb_first into a direction flag for the whole word, shift in the bit, count <= 1, go to SHIFT.
  - SHIFT (count 1..DATA_WIDTH-1): i_msb_first is ignored; the latched flag is used. Each i_bit_valid shifts one bit and increments the count. i_bit_valid=0 holds the state; gaps of any length are allowed.
  - On the edge that accepts bit number DATA_WIDTH: the completed word (including that bit) goes to the output stage, the shift register clears to 0, count <= 0, state returns to IDLE.
- Shift ops:
  - MSB-first: sr <= {sr[DATA_WIDTH-2:0], i_bit}.
  - LSB-first: sr <= {i_bit, sr[DATA_WIDTH-1:1]}.
- o_busy = (state == SHIFT). It is registered-state derived; no combinational path from inputs.
- Output stage, evaluated on the edge of word completion:
  - o_valid=0, or o_valid=1 with i_ready=1: o_data <= word, o_valid <= 1. A back-to-back consume and complete does not set overrun.
  - o_valid=1 and i_ready=0: word dropped, o_data unchanged, o_overrun <= 1.
- Latency: o_valid rises immediately after the edge that samples the last bit, i.e. it is visible in the following cycle.
- Output stage with no word completing: o_valid && i_ready clears o_valid on that edge. o_data keeps its value (not cleared) until overwritten.
- o_data is stable while o_valid=1 and no transfer occurs.
- o_overrun clears only on reset or i_clear.
- Bit collection continues while o_valid is high; there is no backpressure on the serial side.

Test Plan:
- MSB-first: i_msb_first=1, bits 1,1,0,0,0,0,0,1 on 8 consecutive edges -> o_valid=1 the cycle after the 8th bit, o_data=0xC1, o_busy high during bits 2..8, o_overrun=0.
- LSB-first with gaps: i_msb_first=0, same bit sequence with i_bit_valid low for 3 cycles between bits 4 and 5; i_msb_first toggled during the word -> o_data=0x83, no change from the toggle; i_ready=1 for one cycle -> o_valid=0, o_data stays 0x83.
- Overrun: word 0xC1 completes, i_ready held 0, second MSB-first word 0x5A completes -> o_data stays 0xC1, o_valid=1, o_overrun=1. Then i_ready=1 -> o_valid=0, o_overrun stays 1.
- Simultaneous consume and complete: o_valid=1 (0xC1), i_ready=1 on the edge where the 8th bit of 0x5A is sampled -> o_data=0x5A, o_valid=1, o_overrun=0.
- Clear mid-word: 5 bits shifted, then i_clear=1 together with i_bit_valid=1 -> o_busy=0, count 0, o_valid=0, o_overrun=0. A following full 8-bit word 0xC1 decodes correctly as 0xC1.
- Reset mid-word: 3 bits shifted with o_valid=1 pending, i_reset=1 for one edge -> all outputs 0. The next 8 bits yield a correct word with no leftover bits.

Source files
------------

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out word collector with a valid/ready output register.
// Bits arrive MSB- or LSB-first. The direction is latched per word on its first bit.
module shift_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_bit,
  input  logic                  i_bit_valid,
  input  logic                  i_msb_first,
  input  logic                  i_clear,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_overrun
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic                  dir_q, dir_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  logic                  dir_use;
  logic                  done;
  logic [DATA_WIDTH-1:0] shifted;

  // The first bit of a word uses the live direction input. Later bits use the latched flag.
  assign dir_use = (state_q == IDLE) ? i_msb_first : dir_q;
  assign shifted = dir_use ? {sr_q[DATA_WIDTH-2:0], i_bit} : {i_bit, sr_q[DATA_WIDTH-1:1]};
  assign done    = i_bit_valid && (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dir_d   = dir_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (i_bit_valid) begin
      if (done) begin
        sr_d    = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        sr_d    = shifted;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        state_d = SHIFT;
        if (state_q == IDLE) dir_d = i_msb_first;
      end
    end

    if (done) begin
      if (!valid_q || i_ready) begin
        data_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovr_d   = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_busy    = (state_q == SHIFT);
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Self-checking bench for shift_deserializer. It uses a vector table, directed corner sequences and random traffic.
// The random traffic is checked against a queue-based reference model.
module tb_shift_deserializer;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, bit_in, bv, msb, clr, rdy;
  logic [DW-1:0] data;
  logic          valid, busy, ovr;

  int n_tests = 0;
  int n_fail  = 0;

  shift_deserializer #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_bit(bit_in), .i_bit_valid(bv),
    .i_msb_first(msb), .i_clear(clr), .o_data(data), .o_valid(valid),
    .i_ready(rdy), .o_busy(busy), .o_overrun(ovr)
  );

  always #5 clk = ~clk;

  // Reference model: it collects bits in a queue and assembles the word arithmetically once DW bits are held.
  bit            mq[$];
  bit            m_dir;
  logic [DW-1:0] m_data;
  bit            m_valid, m_ovr;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit b, input bit v, input bit m, input bit c, input bit r, input bit rd);
    logic [DW-1:0] w;
    bit            done;
    if (r || c) begin
      mq.delete();
      m_data = '0; m_valid = 0; m_ovr = 0;
    end else begin
      done = 0;
      w = '0;
      if (v) begin
        if (mq.size() == 0) m_dir = m;
        mq.push_back(b);
        if (mq.size() == DW) begin
          for (int i = 0; i < DW; i++)
            if (m_dir) w[DW-1-i] = mq[i]; else w[i] = mq[i];
          mq.delete();
          done = 1;
        end
      end
      if (done) begin
        if (!m_valid || rd) begin m_data = w; m_valid = 1; end
        else m_ovr = 1;
      end else if (m_valid && rd) begin
        m_valid = 0;
      end
    end
  endtask

  // Drive one cycle of inputs and advance the model. Then compare all outputs with the model.
  task automatic step(input bit b, input bit v, input bit m, input bit c, input bit r, input bit rd);
    @(negedge clk);
    bit_in = b; bv = v; msb = m; clr = c; rst = r; rdy = rd;
    @(posedge clk);
    model_edge(b, v, m, c, r, rd);
    #1;
    chk("model_data",    int'(data),  int'(m_data));
    chk("model_valid",   int'(valid), int'(m_valid));
    chk("model_busy",    int'(busy),  int'(mq.size() != 0));
    chk("model_overrun", int'(ovr),   int'(m_ovr));
  endtask

  // Send a full word in transmission order. Ready is asserted only on the last bit.
  task automatic send_word(input logic [DW-1:0] w, input bit m, input bit rd_last);
    for (int i = 0; i < DW; i++)
      step(m ? w[DW-1-i] : w[i], 1'b1, m, 1'b0, 1'b0, (i == DW-1) ? rd_last : 1'b0);
  endtask

  task automatic expect_out(input string name, input int d, input int v, input int bz, input int o);
    chk({name, "_data"},    int'(data),  d);
    chk({name, "_valid"},   int'(valid), v);
    chk({name, "_busy"},    int'(busy),  bz);
    chk({name, "_overrun"}, int'(ovr),   o);
  endtask

  typedef struct {
    bit b, v, m, c, r, rd;
    logic [DW-1:0] e_data;
    bit e_valid, e_busy, e_ovr;
  } vec_t;

  vec_t vt[$];
  vec_t tv;

  initial begin
    logic [DW-1:0] lsb_w;
    bit_in = 0; bv = 0; msb = 0; clr = 0; rst = 1; rdy = 0;
    m_data = '0; m_valid = 0; m_ovr = 0; m_dir = 0;

    // Table: reset, then MSB-first 1,1,0,0,0,0,0,1 produces 0xC1.
    vt.push_back('{0,0,0,0,1,0, 8'h00, 0,0,0});
    vt.push_back('{1,1,1,0,0,0, 8'h00, 0,1,0});
    vt.push_back('{1,1,1,0,0,0, 8'h00, 0,1,0});
    vt.push_back('{0,1,1,0,0,0, 8'h00, 0,1,0});
    vt.push_back('{0,1,1,0,0,0, 8'h00, 0,1,0});
    vt.push_back('{0,1,1,0,0,0, 8'h00, 0,1,0});
    vt.push_back('{0,1,1,0,0,0, 8'h00, 0,1,0});
    vt.push_back('{0,1,1,0,0,0, 8'h00, 0,1,0});
    vt.push_back('{1,1,1,0,0,0, 8'h00, 0,1,0});
    vt[8].e_data = 8'hC1; vt[8].e_valid = 1; vt[8].e_busy = 0;
    foreach (vt[i]) begin
      tv = vt[i];
      step(tv.b, tv.v, tv.m, tv.c, tv.r, tv.rd);
      expect_out($sformatf("vec%0d", i), int'(tv.e_data), int'(tv.e_valid), int'(tv.e_busy), int'(tv.e_ovr));
    end

    // LSB-first with a gap and a direction toggle mid-word.
    step(0,0,0,0,0,1);
    expect_out("consume", 'hC1, 0, 0, 0);
    lsb_w = 8'b1000_0011;
    step(1,1,0,0,0,0); step(1,1,0,0,0,0); step(0,1,1,0,0,0); step(0,1,0,0,0,0);
    step(0,0,1,0,0,0); step(0,0,0,0,0,0); step(0,0,1,0,0,0);
    expect_out("gap_hold", 'hC1, 0, 1, 0);
    step(0,1,1,0,0,0); step(0,1,1,0,0,0); step(0,1,1,0,0,0); step(1,1,1,0,0,0);
    expect_out("lsb_word", int'(lsb_w), 1, 0, 0);
    step(0,0,0,0,0,1);
    expect_out("lsb_consume", 'h83, 0, 0, 0);

    // Overrun: the second word is dropped while the first is still pending.
    send_word(8'hC1, 1, 0);
    send_word(8'h5A, 1, 0);
    expect_out("overrun", 'hC1, 1, 0, 1);
    step(0,0,0,0,0,1);
    expect_out("overrun_consume", 'hC1, 0, 0, 1);

    // Consume on the same edge that completes the next word.
    step(0,0,0,1,0,0);
    expect_out("clear_ovr", 0, 0, 0, 0);
    send_word(8'hC1, 1, 0);
    send_word(8'h5A, 1, 1);
    expect_out("b2b", 'h5A, 1, 0, 0);

    // Clear mid-word: the bit presented with the clear is discarded.
    for (int i = 0; i < 5; i++) step(1,1,1,0,0,0);
    step(1,1,1,1,0,0);
    expect_out("clear_mid", 0, 0, 0, 0);
    send_word(8'hC1, 1, 0);
    expect_out("after_clear", 'hC1, 1, 0, 0);

    // Reset mid-word while a word is still pending.
    step(1,1,0,0,0,0); step(0,1,0,0,0,0); step(1,1,0,0,0,0);
    step(1,1,1,0,1,1);
    expect_out("reset_mid", 0, 0, 0, 0);
    send_word(8'h5A, 1, 0);
    expect_out("after_reset", 'h5A, 1, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(1,0), $urandom_range(3,0) != 0, $urandom_range(1,0),
           $urandom_range(63,0) == 0, $urandom_range(199,0) == 0, $urandom_range(2,0) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
